// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin sharing of one APB master port among NREQ requesters, with a wait-state timeout
module apb_master_arbiter #(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        done,
  output logic                   err,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic [IW-1:0]          grant_id,
  output logic                   PSEL,
  output logic [ADDR_W-1:0]      PADDR,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [DATA_W-1:0]      PWDATA,
  input  logic [DATA_W-1:0]      PRDATA,
  input  logic                   PREADY
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t            r_state;
  logic              r_psel, r_penable, r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic [IW-1:0]     r_gid, r_last, w_win;
  logic [CW-1:0]     r_cnt;
  logic              w_ok, w_to;
  assign w_ok      = (r_state == ACCESS) && PREADY;
  assign w_to      = (r_state == ACCESS) && !PREADY && (r_cnt == CW'(TIMEOUT - 1));
  assign done      = (w_ok || w_to) ? NREQ'(1) << r_gid : '0;
  assign err       = w_to;
  assign rsp_rdata = w_ok ? PRDATA : '0;
  assign grant_id  = r_gid;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  // Round-robin pick: scanning from the farthest offset down lets the nearest set bit after r_last win
  always_comb begin
    w_win = r_last;
    for (int k = NREQ; k >= 1; k--)
      if (req[(int'(r_last) + k) % NREQ]) w_win = IW'((int'(r_last) + k) % NREQ);
  end
  // Transfer sequencer: latch the winner's request in IDLE, then SETUP, then ACCESS until PREADY or timeout
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state   <= IDLE;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_gid     <= '0;
      r_last    <= IW'(NREQ - 1);
      r_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: if (|req) begin
          r_paddr  <= req_addr[w_win*ADDR_W +: ADDR_W];
          r_pwdata <= req_wdata[w_win*DATA_W +: DATA_W];
          r_pwrite <= req_write[w_win];
          r_psel   <= 1'b1;
          r_last   <= w_win;
          r_gid    <= w_win;
          r_state  <= SETUP;
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= '0;
          r_state   <= ACCESS;
        end
        default: if (w_ok || w_to) begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_state   <= IDLE;
        end else r_cnt <= r_cnt + 1'b1;
      endcase
    end
  end
endmodule
